echo_app_stats_log: RTL and testbench
=====================================

ECHO_APP_STATS_LOG -- requirements
Module: echo_app_stats_log

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 8, log2 of entry count (DEPTH = 2^DEPTH_LOG2).
REQ-002 SHALL have port clk  input  1  clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port log_wr_req_val  input  1  one stats record to append this cycle.
REQ-005 SHALL have port log_wr_req_data  input  echo_app_stats_struct  record {timestamp, reqs_done}.
REQ-006 SHALL have port log_rd_req_val  input  1  read request valid.
REQ-007 SHALL have port log_rd_req_addr  input  DEPTH_LOG2  logical index, 0 = oldest stored entry.
REQ-008 SHALL have port log_rd_req_rdy  output  1  read request accepted when val&rdy.
REQ-009 SHALL have port log_rd_resp_val  output  1  read response valid.
REQ-010 SHALL have port log_rd_resp_data  output  echo_app_stats_struct  entry read.
REQ-011 SHALL have port log_rd_resp_hit  output  1  index was within stored entries.
REQ-012 SHALL have port log_rd_resp_rdy  input  1  consumer accepts response.
REQ-013 SHALL have port log_num_entries  output  DEPTH_LOG2+1  stored entry count, saturates at DEPTH.

Function
REQ-014 Write side SHALL never backpressure; every cycle with log_wr_req_val high SHALL store data at wr_ptr and advance wr_ptr by 1 modulo DEPTH.
REQ-015 On wr_ptr wrap DEPTH-1 -> 0, sticky flag wrapped SHALL set; once wrapped, log_num_entries SHALL hold DEPTH and the oldest entry is overwritten.
REQ-016 Oldest physical slot SHALL be 0 when not wrapped, wr_ptr when wrapped; phys = (oldest + addr) mod DEPTH.
REQ-017 Read FSM states: RD_IDLE, RD_WAIT, RD_OUT.
REQ-018 RD_IDLE: log_rd_req_rdy=1; on val SHALL latch phys address and hit = (addr < log_num_entries), using wr_ptr/wrapped/count values registered before that cycle's write, and go to RD_WAIT.
REQ-019 RD_WAIT: RAM data valid; SHALL capture into response register, go to RD_OUT.
REQ-020 RD_OUT: log_rd_resp_val=1, data/hit held stable; on log_rd_resp_rdy SHALL return to RD_IDLE; rdy=0 outside RD_IDLE.
REQ-021 Latency: request accepted cycle N -> log_rd_resp_val high cycle N+2; minimum request spacing 3 cycles.
REQ-022 Miss (hit=0): log_rd_resp_data SHALL be all zeros.
REQ-023 Write to the slot being read in the RAM read cycle SHALL return the old (pre-write) contents.
REQ-024 Writes SHALL continue unaffected while a read is outstanding or stalled in RD_OUT.

Reset
REQ-025 On rst: wr_ptr=0, wrapped=0, log_num_entries=0, FSM=RD_IDLE, log_rd_resp_val=0, log_rd_resp_hit=0, log_rd_resp_data=0; RAM contents not cleared.
REQ-026 Reset mid-read SHALL drop the outstanding response; no response after rst deasserts.

Structure
REQ-027 TIMESTAMP_W, REQS_DONE_W, echo_app_stats_struct and ECHO_STATS_LOG_DEPTH_LOG2 SHALL live in echo_app_stats_pkg.
REQ-028 Storage SHALL be one sub-module ram_1r1w_sync (1 write port, 1 registered read port, read-first), width = struct width.

Verification (DEPTH_LOG2=2)
REQ-029 Write timestamps 10,11,12; read addr 0 and 2 -> data 10 and 12, hit=1; log_num_entries=3.
REQ-030 Write 6 records ts 20..25; read addr 0..3 -> 22,23,24,25 all hit=1; log_num_entries=4.
REQ-031 After 2 writes, read addr 3 -> hit=0, data=0, resp_val at N+2.
REQ-032 Hold log_rd_resp_rdy=0 for 5 cycles while writing every cycle -> resp data stable, rdy=0, no writes lost (count increments per write).
REQ-033 Wrapped log, write and read request accepted same cycle for addr 0 -> returns oldest entry prior to that write.
REQ-034 Assert rst in RD_WAIT -> resp_val stays 0, log_num_entries=0, rdy=1 next cycle.

Source files
------------

// File: rtl/echo_app_stats_pkg.sv
// Shared types for the echo-app statistics log: record layout, default depth, read FSM states.
package echo_app_stats_pkg;

  localparam int unsigned TIMESTAMP_W              = 32;
  localparam int unsigned REQS_DONE_W              = 32;
  localparam int unsigned ECHO_STATS_LOG_DEPTH_LOG2 = 8;

  typedef struct packed {
    logic [TIMESTAMP_W-1:0] timestamp;
    logic [REQS_DONE_W-1:0] reqs_done;
  } echo_app_stats_struct;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_WAIT = 2'd1,
    RD_OUT  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/echo_app_stats_log_if.sv
// Write-append, read-request and read-response channels of the stats log.
interface echo_app_stats_log_if
  import echo_app_stats_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
);
  logic                   log_wr_req_val;
  echo_app_stats_struct   log_wr_req_data;
  logic                   log_rd_req_val;
  logic [DEPTH_LOG2-1:0]  log_rd_req_addr;
  logic                   log_rd_req_rdy;
  logic                   log_rd_resp_val;
  echo_app_stats_struct   log_rd_resp_data;
  logic                   log_rd_resp_hit;
  logic                   log_rd_resp_rdy;
  logic [DEPTH_LOG2:0]    log_num_entries;

  modport master (
    output log_wr_req_val, log_wr_req_data, log_rd_req_val, log_rd_req_addr, log_rd_resp_rdy,
    input  log_rd_req_rdy, log_rd_resp_val, log_rd_resp_data, log_rd_resp_hit, log_num_entries
  );

  modport slave (
    input  log_wr_req_val, log_wr_req_data, log_rd_req_val, log_rd_req_addr, log_rd_resp_rdy,
    output log_rd_req_rdy, log_rd_resp_val, log_rd_resp_data, log_rd_resp_hit, log_num_entries
  );
endinterface

// File: rtl/echo_app_stats_log_ram.sv
// Simple dual-port RAM: one write port, one registered read port, read-first on collision.
module ram_1r1w_sync #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/echo_app_stats_log.sv
// Circular stats log: writes always append (overwriting oldest once full); reads use a logical index from the oldest entry.
module echo_app_stats_log
  import echo_app_stats_pkg::*;
#(
  parameter int DEPTH_LOG2 = ECHO_STATS_LOG_DEPTH_LOG2
) (
  input logic                 clk,
  input logic                 rst,
  echo_app_stats_log_if.slave log_if
);
  localparam int unsigned     DEPTH     = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic                  r_wrapped;
  logic [DEPTH_LOG2:0]   r_count;
  rd_state_e             r_state;
  rd_state_e             w_state_nxt;
  logic                  r_rd_hit;
  echo_app_stats_struct  r_resp_data;
  logic                  r_resp_hit;

  logic [DEPTH_LOG2-1:0] w_oldest;
  logic [DEPTH_LOG2-1:0] w_rd_phys;
  logic                  w_rd_hit;
  logic                  w_req_rdy;
  logic                  w_accept;
  logic                  w_capture;
  logic                  w_resp_val;
  echo_app_stats_struct  w_ram_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_wrapped <= 1'b0;
      r_count   <= '0;
    end else if (log_if.log_wr_req_val) begin
      r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      if (r_wr_ptr == '1)       r_wrapped <= 1'b1;
      if (r_count != DEPTH_CNT) r_count   <= r_count + (DEPTH_LOG2+1)'(1);
    end
  end

  // Address/hit come from pre-write registers, so a same-cycle write never shifts the requested entry.
  assign w_oldest  = r_wrapped ? r_wr_ptr : '0;
  assign w_rd_phys = w_oldest + log_if.log_rd_req_addr;
  assign w_rd_hit  = {1'b0, log_if.log_rd_req_addr} < r_count;

  always_ff @(posedge clk) begin
    if (rst) r_state <= RD_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RD_IDLE: if (log_if.log_rd_req_val)  w_state_nxt = RD_WAIT;
      RD_WAIT:                             w_state_nxt = RD_OUT;
      RD_OUT:  if (log_if.log_rd_resp_rdy) w_state_nxt = RD_IDLE;
      default:                             w_state_nxt = RD_IDLE;
    endcase
  end

  always_comb begin
    w_req_rdy  = (r_state == RD_IDLE);
    w_accept   = (r_state == RD_IDLE) && log_if.log_rd_req_val;
    w_capture  = (r_state == RD_WAIT);
    w_resp_val = (r_state == RD_OUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_hit    <= 1'b0;
      r_resp_data <= '0;
      r_resp_hit  <= 1'b0;
    end else begin
      if (w_accept) r_rd_hit <= w_rd_hit;
      if (w_capture) begin
        r_resp_data <= r_rd_hit ? w_ram_q : '0;
        r_resp_hit  <= r_rd_hit;
      end
    end
  end

  ram_1r1w_sync #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W ($bits(echo_app_stats_struct))
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (log_if.log_wr_req_val),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (log_if.log_wr_req_data),
    .i_rd_en   (w_accept),
    .i_rd_addr (w_rd_phys),
    .o_rd_data (w_ram_q)
  );

  assign log_if.log_rd_req_rdy   = w_req_rdy;
  assign log_if.log_rd_resp_val  = w_resp_val;
  assign log_if.log_rd_resp_data = r_resp_data;
  assign log_if.log_rd_resp_hit  = r_resp_hit;
  assign log_if.log_num_entries  = r_count;
endmodule

// File: tb/tb_echo_app_stats_log.sv
// Directed bench for the stats log at DEPTH_LOG2=2 (4 entries).
module tb_echo_app_stats_log;
  import echo_app_stats_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  echo_app_stats_log_if #(.DEPTH_LOG2(2)) u_if ();

  echo_app_stats_log #(.DEPTH_LOG2(2)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .log_if (u_if.slave)
  );

  function automatic echo_app_stats_struct rec(input int ts);
    echo_app_stats_struct r;
    r.timestamp = 32'(ts);
    r.reqs_done = 32'(ts + 100);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int ts);
    u_if.log_wr_req_val  = 1'b1;
    u_if.log_wr_req_data = rec(ts);
    tick();
    u_if.log_wr_req_val  = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] a, output echo_app_stats_struct d,
                         output logic h, output int lat);
    u_if.log_rd_req_val  = 1'b1;
    u_if.log_rd_req_addr = a;
    tick();
    u_if.log_rd_req_val  = 1'b0;
    lat = 1;
    while (!u_if.log_rd_resp_val && lat < 10) begin
      tick();
      lat++;
    end
    d = u_if.log_rd_resp_data;
    h = u_if.log_rd_resp_hit;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  echo_app_stats_struct d;
  logic h;
  int   lat;

  initial begin
    u_if.log_wr_req_val  = 1'b0;
    u_if.log_wr_req_data = '0;
    u_if.log_rd_req_val  = 1'b0;
    u_if.log_rd_req_addr = '0;
    u_if.log_rd_resp_rdy = 1'b1;

    // Reset state
    do_reset();
    chk("rst_num",  64'(u_if.log_num_entries),  64'd0);
    chk("rst_val",  64'(u_if.log_rd_resp_val),  64'd0);
    chk("rst_rdy",  64'(u_if.log_rd_req_rdy),   64'd1);
    chk("rst_hit",  64'(u_if.log_rd_resp_hit),  64'd0);
    chk("rst_data", 64'(u_if.log_rd_resp_data), 64'd0);

    // Three writes, partial log
    do_write(10); do_write(11); do_write(12);
    chk("p_num", 64'(u_if.log_num_entries), 64'd3);
    do_read(2'd0, d, h, lat);
    chk("p_rd0_data", 64'(d), 64'(rec(10)));
    chk("p_rd0_hit",  64'(h), 64'd1);
    chk("p_rd0_lat",  64'(lat), 64'd2);
    do_read(2'd2, d, h, lat);
    chk("p_rd2_data", 64'(d), 64'(rec(12)));
    chk("p_rd2_hit",  64'(h), 64'd1);

    // Six writes wrap a 4-deep log: oldest is ts 22
    do_reset();
    for (int i = 20; i <= 25; i++) do_write(i);
    chk("w_num", 64'(u_if.log_num_entries), 64'd4);
    for (int a = 0; a < 4; a++) begin
      do_read(2'(a), d, h, lat);
      chk($sformatf("w_rd%0d_data", a), 64'(d), 64'(rec(22 + a)));
      chk($sformatf("w_rd%0d_hit", a),  64'(h), 64'd1);
    end

    // Miss beyond stored entries
    do_reset();
    do_write(30); do_write(31);
    do_read(2'd3, d, h, lat);
    chk("m_rd3_hit",  64'(h), 64'd0);
    chk("m_rd3_data", 64'(d), 64'd0);
    chk("m_rd3_lat",  64'(lat), 64'd2);
    do_read(2'd2, d, h, lat);
    chk("m_rd2_hit",  64'(h), 64'd0);
    do_read(2'd1, d, h, lat);
    chk("m_rd1_data", 64'(d), 64'(rec(31)));
    chk("m_rd1_hit",  64'(h), 64'd1);

    // Stalled response while writing every cycle
    u_if.log_rd_resp_rdy = 1'b0;
    u_if.log_rd_req_val  = 1'b1;
    u_if.log_rd_req_addr = 2'd0;
    tick();
    u_if.log_rd_req_val  = 1'b0;
    chk("s_rdy_wait", 64'(u_if.log_rd_req_rdy), 64'd0);
    tick();
    chk("s_val", 64'(u_if.log_rd_resp_val), 64'd1);
    for (int k = 1; k <= 5; k++) begin
      u_if.log_wr_req_val  = 1'b1;
      u_if.log_wr_req_data = rec(39 + k);
      tick();
      chk($sformatf("s_data%0d", k), 64'(u_if.log_rd_resp_data), 64'(rec(30)));
      chk($sformatf("s_val%0d", k),  64'(u_if.log_rd_resp_val),  64'd1);
      chk($sformatf("s_rdy%0d", k),  64'(u_if.log_rd_req_rdy),   64'd0);
      chk($sformatf("s_num%0d", k),  64'(u_if.log_num_entries),  64'((2 + k > 4) ? 4 : 2 + k));
    end
    u_if.log_wr_req_val  = 1'b0;
    u_if.log_rd_resp_rdy = 1'b1;
    tick();
    chk("s_release_rdy", 64'(u_if.log_rd_req_rdy),  64'd1);
    chk("s_release_val", 64'(u_if.log_rd_resp_val), 64'd0);
    do_read(2'd0, d, h, lat);
    chk("s_oldest", 64'(d), 64'(rec(41)));

    // Same-cycle write and read of oldest slot returns pre-write contents
    u_if.log_wr_req_val  = 1'b1;
    u_if.log_wr_req_data = rec(50);
    u_if.log_rd_req_val  = 1'b1;
    u_if.log_rd_req_addr = 2'd0;
    tick();
    u_if.log_wr_req_val  = 1'b0;
    u_if.log_rd_req_val  = 1'b0;
    lat = 1;
    while (!u_if.log_rd_resp_val && lat < 10) begin
      tick();
      lat++;
    end
    chk("c_data", 64'(u_if.log_rd_resp_data), 64'(rec(41)));
    chk("c_lat",  64'(lat), 64'd2);
    tick();
    do_read(2'd0, d, h, lat);
    chk("c_new_oldest", 64'(d), 64'(rec(42)));
    do_read(2'd3, d, h, lat);
    chk("c_newest", 64'(d), 64'(rec(50)));

    // Reset while the read sits in RD_WAIT
    u_if.log_rd_req_val  = 1'b1;
    u_if.log_rd_req_addr = 2'd1;
    tick();
    u_if.log_rd_req_val  = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r_val", 64'(u_if.log_rd_resp_val), 64'd0);
    chk("r_num", 64'(u_if.log_num_entries), 64'd0);
    chk("r_rdy", 64'(u_if.log_rd_req_rdy),  64'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("r_noresp%0d", k), 64'(u_if.log_rd_resp_val), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
